// File: rtl/rx_fifo.sv
// Receive-side AXI-stream to AHIR pipe adapter: packs beats into {tlast, tdata, tkeep} words,
// buffers them in a DEPTH-entry circular FIFO and counts good/bad frames flagged via tuser.
module rx_fifo #(
   parameter int unsigned N     = 64,
   parameter int unsigned S     = N / 8,
   parameter int unsigned D     = N + S + 1,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] rx_axis_tdata,
   input  logic [S-1:0] rx_axis_tkeep,
   input  logic         rx_axis_tvalid,
   input  logic         rx_axis_tlast,
   input  logic         rx_axis_tuser,
   output logic         rx_axis_tready,
   output logic [D-1:0] write_pipe_data,
   output logic         write_pipe_req,
   input  logic         write_pipe_ack,
   output logic         rx_frame_active,
   output logic [15:0]  rx_good_frames,
   output logic [15:0]  rx_bad_frames
);

   typedef enum logic [0:0] {StIdle, StFrame} state_e;

   localparam logic [AW:0] CountFull = (AW + 1)'(DEPTH);

   logic [D-1:0]  mem_q [DEPTH];
   logic [D-1:0]  mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          ready_en_q, ready_en_d;
   logic [15:0]   good_q, good_d;
   logic [15:0]   bad_q, bad_d;
   state_e        state_q, state_d;

   logic full, empty, push, pop;

   always_comb begin
      full            = (count_q == CountFull);
      empty           = (count_q == '0);
      // tready depends only on registered state, never on write_pipe_ack.
      rx_axis_tready  = ready_en_q && !full;
      write_pipe_req  = !empty;
      write_pipe_data = mem_q[rd_ptr_q];
      push            = rx_axis_tvalid && rx_axis_tready;
      pop             = write_pipe_req && write_pipe_ack;
      rx_good_frames  = good_q;
      rx_bad_frames   = bad_q;
   end

   always_comb begin
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      ready_en_d = 1'b1;
      good_d     = good_q;
      bad_d      = bad_q;
      if (push) begin
         mem_d[wr_ptr_q] = {rx_axis_tlast, rx_axis_tdata, rx_axis_tkeep};
         wr_ptr_d        = wr_ptr_q + AW'(1);
         if (rx_axis_tlast) begin
            if (rx_axis_tuser) bad_d = bad_q + 16'd1;
            else               good_d = good_q + 16'd1;
         end
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push, pop})
         2'b10:   count_d = count_q + (AW + 1)'(1);
         2'b01:   count_d = count_q - (AW + 1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Storage has no reset; emptiness is tracked solely by count_q.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         ready_en_q <= 1'b0;
         good_q     <= '0;
         bad_q      <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         ready_en_q <= ready_en_d;
         good_q     <= good_d;
         bad_q      <= bad_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= StIdle;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (push) begin
         unique case (state_q)
            StIdle:  if (!rx_axis_tlast) state_d = StFrame;
            StFrame: if (rx_axis_tlast)  state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      rx_frame_active = (state_q == StFrame);
   end

endmodule

// File: tb/tb_rx_fifo.sv
// Directed bench for rx_fifo: table-driven streaming vectors plus hand-written sequences for
// back-pressure, randomized stalls, asynchronous reset and counter wrap.
module tb_rx_fifo;

   localparam int unsigned N = 64;
   localparam int unsigned S = 8;
   localparam int unsigned D = N + S + 1;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [N-1:0] tdata = '0;
   logic [S-1:0] tkeep = '0;
   logic         tvalid = 1'b0;
   logic         tlast = 1'b0;
   logic         tuser = 1'b0;
   logic         tready;
   logic [D-1:0] pdata;
   logic         preq;
   logic         pack = 1'b0;
   logic         active;
   logic [15:0]  good;
   logic [15:0]  bad;

   rx_fifo #(.N(N), .S(S), .D(D), .DEPTH(4), .AW(2)) dut (
      .clk             (clk),
      .reset           (reset),
      .rx_axis_tdata   (tdata),
      .rx_axis_tkeep   (tkeep),
      .rx_axis_tvalid  (tvalid),
      .rx_axis_tlast   (tlast),
      .rx_axis_tuser   (tuser),
      .rx_axis_tready  (tready),
      .write_pipe_data (pdata),
      .write_pipe_req  (preq),
      .write_pipe_ack  (pack),
      .rx_frame_active (active),
      .rx_good_frames  (good),
      .rx_bad_frames   (bad)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        tvalid;
      logic [63:0] tdata;
      logic [7:0]  tkeep;
      logic        tlast;
      logic        tuser;
      logic        exp_req;
      logic        exp_active;
      logic [15:0] exp_good;
      logic [15:0] exp_bad;
   } vec_t;

   vec_t         tbl [12];
   int           errors = 0;
   int           checks = 0;
   int           accepted = 0;
   int           seq = 0;
   logic [D-1:0] sb [$];

   function automatic logic [D-1:0] word(input logic l, input logic [63:0] d, input logic [7:0] k);
      return {l, d, k};
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One cycle with scoreboard: pops compared before the edge, pushes recorded after it.
   task automatic cycle(input logic v, input logic l, input logic u, input logic a);
      logic         do_push;
      logic [D-1:0] w;
      tvalid = v;
      tdata  = {32'hC0DE_0000, 32'(seq)};
      tkeep  = 8'(seq * 3 + 1);
      tlast  = l;
      tuser  = u;
      pack   = a;
      w      = word(l, tdata, tkeep);
      #1;
      do_push = tvalid && tready;
      if (preq && pack) begin
         if (sb.size() == 0) check("pop_unexpected", 128'(pdata), 128'(0));
         else check("pop_data", 128'(pdata), 128'(sb.pop_front()));
      end
      @(posedge clk);
      #1;
      if (do_push) begin
         sb.push_back(w);
         accepted++;
         seq++;
      end
   endtask

   initial begin
      tbl[0]  = '{1, 64'hA0A0_0000_0000_0000, 8'hFF, 0, 0, 1, 1, 16'd1, 16'd0};
      tbl[1]  = '{1, 64'hA0A0_0000_0000_0001, 8'hFF, 0, 0, 1, 1, 16'd1, 16'd0};
      tbl[2]  = '{1, 64'hA0A0_0000_0000_0002, 8'hFF, 0, 0, 1, 1, 16'd1, 16'd0};
      tbl[3]  = '{1, 64'hA0A0_0000_0000_0003, 8'hFF, 0, 0, 1, 1, 16'd1, 16'd0};
      tbl[4]  = '{1, 64'hA0A0_0000_0000_0004, 8'hFF, 0, 0, 1, 1, 16'd1, 16'd0};
      tbl[5]  = '{1, 64'hA0A0_0000_0000_0005, 8'hFF, 0, 0, 1, 1, 16'd1, 16'd0};
      tbl[6]  = '{1, 64'hA0A0_0000_0000_0006, 8'hFF, 0, 0, 1, 1, 16'd1, 16'd0};
      tbl[7]  = '{1, 64'hA0A0_0000_0000_0007, 8'h0F, 1, 0, 1, 0, 16'd2, 16'd0};
      tbl[8]  = '{1, 64'hBAD0_0000_0000_0008, 8'hFF, 0, 0, 1, 1, 16'd2, 16'd0};
      tbl[9]  = '{1, 64'hBAD0_0000_0000_0009, 8'hFF, 0, 1, 1, 1, 16'd2, 16'd0};
      tbl[10] = '{1, 64'hBAD0_0000_0000_000A, 8'h3F, 1, 1, 1, 0, 16'd2, 16'd1};
      tbl[11] = '{0, 64'h0,                   8'h00, 0, 0, 0, 0, 16'd2, 16'd1};

      // Reset state
      #12;
      check("rst_tready", 128'(tready), 128'(0));
      check("rst_req", 128'(preq), 128'(0));
      check("rst_active", 128'(active), 128'(0));
      check("rst_good", 128'(good), 128'(0));
      check("rst_bad", 128'(bad), 128'(0));
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("tready_rise", 128'(tready), 128'(1));

      // Single-beat frame
      tvalid = 1'b1; tdata = 64'h0123_4567_89AB_CDEF; tkeep = 8'hFF; tlast = 1'b1; pack = 1'b1;
      @(posedge clk);
      #1;
      tvalid = 1'b0;
      check("single_req", 128'(preq), 128'(1));
      check("single_data", 128'(pdata), 128'(word(1'b1, 64'h0123_4567_89AB_CDEF, 8'hFF)));
      check("single_good", 128'(good), 128'(1));
      check("single_active", 128'(active), 128'(0));
      @(posedge clk);
      #1;
      check("single_drained", 128'(preq), 128'(0));

      // Streaming good frame then bad frame, ack held high
      for (int i = 0; i < 12; i++) begin
         tvalid = tbl[i].tvalid; tdata = tbl[i].tdata; tkeep = tbl[i].tkeep;
         tlast = tbl[i].tlast; tuser = tbl[i].tuser; pack = 1'b1;
         #1;
         check($sformatf("tbl%0d_tready", i), 128'(tready), 128'(1));
         @(posedge clk);
         #1;
         check($sformatf("tbl%0d_req", i), 128'(preq), 128'(tbl[i].exp_req));
         if (tbl[i].exp_req)
            check($sformatf("tbl%0d_data", i), 128'(pdata),
                  128'(word(tbl[i].tlast, tbl[i].tdata, tbl[i].tkeep)));
         check($sformatf("tbl%0d_active", i), 128'(active), 128'(tbl[i].exp_active));
         check($sformatf("tbl%0d_good", i), 128'(good), 128'(tbl[i].exp_good));
         check($sformatf("tbl%0d_bad", i), 128'(bad), 128'(tbl[i].exp_bad));
      end

      // Back-pressure: exactly four beats, then stall until a single pop
      accepted = 0;
      for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
      check("bp_accepted", 128'(accepted), 128'(4));
      check("bp_tready", 128'(tready), 128'(0));
      check("bp_req", 128'(preq), 128'(1));
      check("bp_data_hold", 128'(pdata), 128'(sb[0]));
      cycle(1'b1, 1'b0, 1'b0, 1'b1);
      check("bp_tready_after_pop", 128'(tready), 128'(1));
      check("bp_accepted_hold", 128'(accepted), 128'(4));

      // Randomized stalls on both sides
      for (int i = 0; i < 200; i++)
         cycle(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'($urandom_range(0, 1)));
      for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
      check("rand_sb_empty", 128'(sb.size()), 128'(0));
      check("rand_req_low", 128'(preq), 128'(0));

      // Asynchronous reset with a partial frame buffered
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
      check("mid_active", 128'(active), 128'(1));
      tvalid = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      check("arst_tready", 128'(tready), 128'(0));
      check("arst_req", 128'(preq), 128'(0));
      check("arst_active", 128'(active), 128'(0));
      check("arst_good", 128'(good), 128'(0));
      check("arst_bad", 128'(bad), 128'(0));
      sb.delete();
      #3;
      reset = 1'b0;
      @(posedge clk);
      #1;
      cycle(1'b1, 1'b0, 1'b0, 1'b1);
      cycle(1'b1, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
      check("post_rst_sb_empty", 128'(sb.size()), 128'(0));
      check("post_rst_good", 128'(good), 128'(1));
      check("post_rst_active", 128'(active), 128'(0));

      // Good-frame counter wrap
      reset = 1'b1;
      #3;
      reset = 1'b0;
      @(posedge clk);
      #1;
      tvalid = 1'b1; tlast = 1'b1; tuser = 1'b0; pack = 1'b1;
      repeat (65535) @(posedge clk);
      #1;
      check("wrap_ffff", 128'(good), 128'(16'hFFFF));
      check("wrap_bad", 128'(bad), 128'(0));
      @(posedge clk);
      #1;
      tvalid = 1'b0;
      check("wrap_zero", 128'(good), 128'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rx_fifo.md
# rx_fifo

Receive-side counterpart of the MAC transmit path. Accepts AXI-stream beats from the MAC receiver, packs each beat into a {tlast, tdata, tkeep} word and writes it into an AHIR pipe through a req/ack write interface. A DEPTH-entry circular buffer absorbs pipe back-pressure. Per-frame good and bad counters report frames that the MAC flags with tuser on the last beat.

## Interface
- N, 64, AXI-s data width in bits
- S, 8, tkeep width (N/8)
- D, N+S+1, pipe word width
- DEPTH, 4, buffer entries; power of two, at least 2
- AW, 2, log2(DEPTH)

- clk  in  1  sole clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-high reset
- rx_axis_tdata  in  N  beat data
- rx_axis_tkeep  in  S  byte enables
- rx_axis_tvalid  in  1  beat valid
- rx_axis_tlast  in  1  last beat of frame
- rx_axis_tuser  in  1  frame error; meaningful only on the tlast beat
- rx_axis_tready  out  1  block can accept a beat
- write_pipe_data  out  D  {tlast, tdata, tkeep}: bit D-1 is tlast, [D-2:S] is tdata, [S-1:0] is tkeep
- write_pipe_req  out  1  write_pipe_data is valid
- write_pipe_ack  in  1  pipe accepts the word
- rx_frame_active  out  1  at least one beat of the current frame has been accepted, and its tlast has not
- rx_good_frames  out  16  count of frames ended with tuser=0
- rx_bad_frames  out  16  count of frames ended with tuser=1

## Operation
- Buffer: mem[DEPTH] of D bits; wr_ptr and rd_ptr are AW bits and wrap modulo DEPTH. count runs 0..DEPTH, AW+1 bits. full = (count==DEPTH); empty = (count==0).
- Accept: a beat is taken when rx_axis_tvalid && rx_axis_tready at the clock edge. mem[wr_ptr] <= {tlast, tdata, tkeep}, then wr_ptr++.
- rx_axis_tready = ready_en && !full. ready_en is a flop cleared by reset and set on the first clk edge after reset falls.
  - tready has no combinational path from write_pipe_ack.
  - When full, tready stays 0 for the whole cycle, even if a pop happens in that same cycle.
- Drain:
  - write_pipe_req = !empty and write_pipe_data = mem[rd_ptr], both driven combinationally from registered state.
  - A pop occurs when write_pipe_req && write_pipe_ack at the edge; rd_ptr++.
  - With no ack, req and data hold stable.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Frame FSM, two states:
  - IDLE to FRAME on an accepted beat with tlast=0.
  - FRAME to IDLE on an accepted beat with tlast=1.
  - An accepted tlast beat in IDLE (single-beat frame) stays in IDLE.
  - rx_frame_active = (state==FRAME).
- Counters: on every accepted tlast beat, rx_bad_frames++ if tuser=1, otherwise rx_good_frames++. Both wrap 0xFFFF to 0x0000.
  - tuser on non-last beats is ignored.
  - Data is never dropped; error frames are forwarded intact.
- Reset mid-operation: buffer contents are discarded, pointers, count, FSM and counters are cleared, and a partial frame is lost.

## Timing
- Reset values: rx_axis_tready=0, write_pipe_req=0, rx_frame_active=0, rx_good_frames=0, rx_bad_frames=0. write_pipe_data is don't-care while req=0.
- rx_axis_tready rises on the first edge after reset deasserts.
- Latency: a beat accepted at edge k into an empty buffer gives write_pipe_req=1 with that word during cycle k+1.
- Throughput: one beat per cycle sustained when ack is held high.
- Back-pressure: with ack=0, exactly DEPTH beats are accepted and then tready=0. After a pop at edge j, tready=1 in cycle j+1.
- Counters and rx_frame_active update at the edge that accepts the relevant beat.

## Test plan
- Reset then a single beat (tdata=0x0123456789ABCDEF, tkeep=0xFF, tlast=1, tuser=0) with ack=1 -> req=1 one cycle later with write_pipe_data={1, 0x0123456789ABCDEF, 0xFF}; rx_good_frames=1; rx_frame_active stays 0.
- 8-beat frame streamed with tvalid=1 and ack=1 -> 8 pipe words in order with no gaps; tready constant 1; rx_frame_active=1 from beat 1 until the tlast edge; last word has tlast=1 and its tkeep passed through (e.g. 0x0F).
- ack=0 while tvalid=1 -> 4 beats accepted, then tready=0 with req held and data stable. Raise ack for one cycle -> one pop, and tready=1 the next cycle. No beat is lost or duplicated across 20 randomized stalls.
- Frame ending with tuser=1 (tuser=1 also driven on a middle beat) -> all words forwarded; rx_bad_frames=1, rx_good_frames unchanged.
- Preload rx_good_frames to 0xFFFF via 65535 frames, then one more good frame -> rx_good_frames=0x0000.
- Assert reset asynchronously mid-frame with 3 words buffered -> tready and req drop immediately and all status outputs read 0. After release, a fresh frame is received correctly with no stale words.
